lsu_bridge: RTL
===============

LSU_BRIDGE -- requirements
Module: lsu_bridge

Interface
REQ-001 Parameter NDEV, default 3: number of device channels, legal 1..8.
REQ-002 Parameter DEV_BASE, default {32'h7F20,32'h7F00,32'h0000}: NDEV*32 packed base addresses; channel i is slice [32i+31:32i].
REQ-003 Parameter DEV_LIMIT, default {32'h7F3B,32'h7F0B,32'h2FFF}: NDEV*32 packed inclusive upper addresses.
REQ-004 Parameter WORD_ONLY, default 3'b010: NDEV-bit mask; set bit means the channel rejects sub-word access.
REQ-005 Parameter TIMEOUT, default 15: maximum REQ cycles before bus error, legal 1..255.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 op_valid  in  1  memory operation present in stage.
REQ-009 op  in  4  0 lw, 1 sb, 2 sh, 3 sw, 4 lb, 5 lbu, 6 lh, 7 lhu; other codes are no-ops.
REQ-010 addr  in  32  byte address; wdata  in  32  store data, unshifted.
REQ-011 kill  in  1  interrupt/exception this cycle; suppresses acceptance.
REQ-012 stall  out  1  hold upstream pipeline.
REQ-013 done  out  1  one-cycle pulse, transaction complete; rdata  out  32  extended load result, valid with done.
REQ-014 exc  out  1  exception pulse; exc_code  out  5  4 AdEL, 5 AdES, 7 bus error.
REQ-015 dev_req  out  NDEV  one-hot request; dev_we  out  1; dev_addr  out  32; dev_wdata  out  32 lane-shifted; dev_byteen  out  4.
REQ-016 dev_rdata  in  NDEV*32  per-channel read data; dev_ack  in  NDEV  per-channel completion.

Function
REQ-017 Decode SHALL be combinational: hit[i] = DEV_BASE[i] <= addr <= DEV_LIMIT[i]; lowest index wins on overlap.
REQ-018 Misaligned (word addr[1:0]!=0, half addr[0]!=0), unmapped, or sub-word op to a WORD_ONLY channel SHALL raise AdEL for loads, AdES for stores.
REQ-019 States: IDLE, REQ, DONE.
REQ-020 IDLE: op_valid & legal op & !kill & no address fault -> latch addr/wdata/byteen/channel/op, go REQ; stall=1 this cycle.
REQ-021 IDLE with address fault & op_valid & !kill: exc=1 with code this cycle, no request, stay IDLE, stall=0.
REQ-022 REQ: dev_req[ch]=1 and dev_* driven from latches; stall=1; wait counter increments each cycle.
REQ-023 REQ with dev_ack[ch]=1: capture dev_rdata[ch] extended per op, go DONE.
REQ-024 REQ with counter == TIMEOUT and no ack: exc=1 code 7, dev_req dropped, go IDLE; ack in that same cycle wins (no exc).
REQ-025 DONE: done=1, rdata valid, stall=0, next IDLE; minimum op_valid-to-done latency 2 cycles.
REQ-026 kill SHALL be sampled only in IDLE; an issued transaction always completes.
REQ-027 Byte enables: sb 0001<<addr[1:0]; sh 0011 or 1100 by addr[1]; sw 1111; loads 0000, dev_we=0.
REQ-028 dev_wdata: sb wdata<<8*addr[1:0]; sh wdata<<16*addr[1]; sw unshifted.
REQ-029 Load extend: lb/lh sign, lbu/lhu zero, from selected lane; lw unmodified; stores give rdata=0.
REQ-030 dev_ack on a non-selected channel SHALL be ignored.

Reset
REQ-031 reset -> IDLE, counter 0; stall, done, exc, dev_req, dev_we, dev_byteen 0; exc_code, rdata, dev_addr, dev_wdata 0.
REQ-032 Reset in REQ SHALL drop dev_req the following cycle, no done/exc.

Structure
REQ-033 op encodings, exc codes and state encodings SHALL live in shared package lsu_pkg.
REQ-034 One sub-module lsu_lane (byteen, wdata shift, load extension, combinational); FSM and decode in lsu_bridge.

Verification
REQ-035 lw 0x1004, ack in first REQ cycle, dev_rdata[0]=0x8899AABB -> done cycle 2, rdata 0x8899AABB, stall cycles 0-1.
REQ-036 sb 0x0003 wdata 0x000000C5 -> dev_byteen 1000, dev_wdata 0xC5000000, dev_we=1.
REQ-037 lh 0x7F21 -> exc cycle 0, code 4, dev_req stays 0; sb 0x7F04 -> code 5.
REQ-038 lw 0x7F20, ack never -> exc code 7 after 15 REQ cycles, dev_req falls, IDLE.
REQ-039 lb 0x0002 dev_rdata 0x00F10000 -> rdata 0xFFFFFFF1; lbu -> 0x000000F1.
REQ-040 kill with op_valid in IDLE -> no request; reset during REQ -> dev_req 0 next cycle, no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bridge: op codes, exception codes, FSM states.
// Pure declarations; no latency and no flow control of its own.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LW  = 4'd0,
        OP_SB  = 4'd1,
        OP_SH  = 4'd2,
        OP_SW  = 4'd3,
        OP_LB  = 4'd4,
        OP_LBU = 4'd5,
        OP_LH  = 4'd6,
        OP_LHU = 4'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_BUS  = 5'd7;

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_word(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic op_is_half(input logic [3:0] op);
        return (op == OP_SH) || (op == OP_LH) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables/data shift and load extension; purely
// combinational, zero latency, no flow control.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byteen,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_byteen = 4'b0000;
        o_wdata  = i_wdata;
        o_rdata  = '0;
        case (i_op)
            OP_SB: begin
                o_byteen = 4'b0001 << i_addr_lo;
                o_wdata  = i_wdata << {i_addr_lo, 3'b000};
            end
            OP_SH: begin
                o_byteen = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata  = i_addr_lo[1] ? {i_wdata[15:0], 16'h0000} : i_wdata;
            end
            OP_SW:  o_byteen = 4'b1111;
            OP_LW:  o_rdata  = i_rdata;
            OP_LB:  o_rdata  = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_rdata  = {24'h000000, w_byte};
            OP_LH:  o_rdata  = {{16{w_half[15]}}, w_half};
            OP_LHU: o_rdata  = {16'h0000, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_bridge.sv
// Load/store unit to NDEV memory-mapped channels; done >= 2 cycles after op_valid.
// Stalls upstream while a transaction is outstanding; device backpressure is the ack wait (bounded by TIMEOUT).
module lsu_bridge
    import lsu_pkg::*;
#(
    parameter int                 NDEV      = 3,
    parameter logic [NDEV*32-1:0] DEV_BASE  = {32'h7F20, 32'h7F00, 32'h0000},
    parameter logic [NDEV*32-1:0] DEV_LIMIT = {32'h7F3B, 32'h7F0B, 32'h2FFF},
    parameter logic [NDEV-1:0]    WORD_ONLY = 3'b010,
    parameter int                 TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    input  logic [3:0]           op,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 kill,
    output logic                 stall,
    output logic                 done,
    output logic [31:0]          rdata,
    output logic                 exc,
    output logic [4:0]           exc_code,
    output logic [NDEV-1:0]      dev_req,
    output logic                 dev_we,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wdata,
    output logic [3:0]           dev_byteen,
    input  logic [NDEV*32-1:0]   dev_rdata,
    input  logic [NDEV-1:0]      dev_ack
);

    state_e        r_state, w_next;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic [3:0]    r_op;
    logic [2:0]    r_ch;
    logic [7:0]    r_cnt;

    logic          w_hit, w_wo, w_misalign, w_fault, w_start, w_accept, w_afault;
    logic [2:0]    w_ch;
    logic [NDEV-1:0] w_sel;
    logic [31:0]   w_sel_rdata, w_ext, w_lane_wdata;
    logic [3:0]    w_lane_be;
    logic          w_ack, w_tmo;

    // Scan high to low so the lowest matching channel overrides on overlap.
    always_comb begin
        w_hit = 1'b0;
        w_ch  = '0;
        w_wo  = 1'b0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (addr >= DEV_BASE[32*i +: 32] && addr <= DEV_LIMIT[32*i +: 32]) begin
                w_hit = 1'b1;
                w_ch  = 3'(i);
                w_wo  = WORD_ONLY[i];
            end
        end
    end

    always_comb begin
        w_sel       = '0;
        w_sel_rdata = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (r_ch == 3'(i)) begin
                w_sel[i]    = 1'b1;
                w_sel_rdata = dev_rdata[32*i +: 32];
            end
        end
    end

    assign w_ack      = |(w_sel & dev_ack);
    assign w_tmo      = (r_cnt == 8'(TIMEOUT));
    assign w_misalign = (op_is_word(op) && addr[1:0] != 2'b00) || (op_is_half(op) && addr[0]);
    assign w_fault    = !w_hit || w_misalign || (!op_is_word(op) && w_wo);
    assign w_start    = (r_state == ST_IDLE) && op_valid && !op[3] && !kill;
    assign w_accept   = w_start && !w_fault;
    assign w_afault   = w_start && w_fault;

    lsu_lane u_lane (
        .i_op      (r_op),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (w_sel_rdata),
        .o_byteen  (w_lane_be),
        .o_wdata   (w_lane_wdata),
        .o_rdata   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_REQ;
            ST_REQ: begin
                if (w_ack)      w_next = ST_DONE;
                else if (w_tmo) w_next = ST_IDLE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Counter reads 1 in the first REQ cycle so it equals the number of REQ cycles elapsed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= '0;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_op    <= op;
                r_ch    <= w_ch;
                r_cnt   <= 8'd1;
            end else if (r_state == ST_REQ) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= '0;
            end
            if (r_state == ST_REQ && w_ack) r_rdata <= w_ext;
        end
    end

    always_comb begin
        stall      = 1'b0;
        done       = 1'b0;
        exc        = 1'b0;
        exc_code   = '0;
        dev_req    = '0;
        dev_we     = 1'b0;
        dev_addr   = '0;
        dev_wdata  = '0;
        dev_byteen = '0;
        case (r_state)
            ST_IDLE: begin
                stall = w_accept;
                if (w_afault) begin
                    exc      = 1'b1;
                    exc_code = op_is_store(op) ? EXC_ADES : EXC_ADEL;
                end
            end
            ST_REQ: begin
                stall      = 1'b1;
                dev_req    = w_sel;
                dev_we     = op_is_store(r_op);
                dev_addr   = r_addr;
                dev_wdata  = w_lane_wdata;
                dev_byteen = w_lane_be;
                if (!w_ack && w_tmo) begin
                    exc      = 1'b1;
                    exc_code = EXC_BUS;
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign rdata = r_rdata;

endmodule
